clk_ctrl: RTL and testbench
===========================

CLK_CTRL -- requirements
Module: clk_ctrl

Interface
REQ-001 The block SHALL declare parameter DIV_W, default 8, as the width of the divide-ratio register.
REQ-002 The block SHALL declare parameter DEFAULT_DIV, default 10, as the divide ratio loaded at reset.
REQ-003 The block SHALL declare parameter CNT_W, default 16, as the width of the issued-tick counter.
REQ-004 The block SHALL declare parameter DEB_CYCLES, default 255, as the step-button stable-high time in clk cycles; it is used only with the debounce macro.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 HALT, 01 RUN, 10 STEP, 11 treated as HALT.
REQ-008 The block SHALL have port div_val, input, DIV_W bits: new divide ratio.
REQ-009 The block SHALL have port div_load, input, 1 bit: single-cycle request to load div_val.
REQ-010 The block SHALL have port step_req, input, 1 bit: asynchronous step button, active-high.
REQ-011 The block SHALL have port clr_count, input, 1 bit: synchronous clear of tick_count.
REQ-012 The block SHALL have port cpu_ce, output, 1 bit: single-cycle clock-enable pulse for the CPU.
REQ-013 The block SHALL have port div_ack, output, 1 bit: single-cycle pulse when a loaded ratio takes effect.
REQ-014 The block SHALL have port tick_count, output, CNT_W bits: number of cpu_ce pulses issued.
REQ-015 The block SHALL have port state, output, 2 bits: current FSM state encoding.

Function
REQ-016 The FSM SHALL have states S_HALT=00, S_RUN=01, S_STEP_ARM=10 and S_STEP_FIRE=11.
REQ-017 The FSM transitions SHALL be:
- any state -> S_HALT when mode is 00 or 11;
- any state -> S_RUN when mode is 01;
- S_HALT or S_RUN -> S_STEP_ARM when mode is 10;
- S_STEP_ARM -> S_STEP_FIRE on a qualified step edge;
- S_STEP_FIRE -> S_STEP_ARM unconditionally.
REQ-018 In S_RUN, div_cnt SHALL count 0..div_reg; when div_cnt==div_reg it SHALL assert cpu_ce for exactly one cycle and wrap div_cnt to 0, giving a period of div_reg+1 cycles.
REQ-019 div_reg==0 SHALL give cpu_ce high on every cycle while in S_RUN.
REQ-020 Leaving S_RUN SHALL clear div_cnt to 0 with no cpu_ce; re-entering S_RUN SHALL restart the count from 0.
REQ-021 In S_STEP_FIRE, cpu_ce SHALL be high for exactly one cycle; S_HALT and S_STEP_ARM SHALL never assert cpu_ce.
REQ-022 A qualified step edge SHALL be a 0->1 transition of the synchronized (and, if enabled, debounced) step_req, and it SHALL produce at most one cpu_ce.
REQ-023 Step edges occurring outside S_STEP_ARM SHALL be discarded and not queued.
REQ-024 Latency from the step_req rising edge to cpu_ce SHALL be 4 cycles without debounce (2 synchronizer flops, edge register, FIRE state).
REQ-025 div_load SHALL capture div_val into a pending register and set a pending flag.
REQ-026 A pending ratio SHALL apply on the next S_RUN wrap cycle, or on the next cycle if the FSM is not in S_RUN; div_ack SHALL pulse for one cycle in the cycle the ratio applies.
REQ-027 A second div_load arriving while a load is pending SHALL overwrite the pending value, with one div_ack issued.
REQ-028 When div_load coincides with a wrap, the current period SHALL finish with the old ratio and the new ratio SHALL apply from the following period.
REQ-029 tick_count SHALL increment on each cpu_ce and wrap from 2^CNT_W-1 to 0.
REQ-030 When clr_count and cpu_ce occur in the same cycle, tick_count SHALL become 0 (clear wins).

Reset
REQ-031 While reset is high, the state SHALL be S_HALT, div_cnt 0, div_reg DEFAULT_DIV, pending flag 0, tick_count 0, and cpu_ce and div_ack 0.
REQ-032 While reset is high, the synchronizer, edge and debounce registers SHALL be held at 0.
REQ-033 A reset asserted mid-period or mid-step SHALL abort the operation, with no cpu_ce emitted afterwards.

Configuration
REQ-034 When CLK_CTRL_DEBOUNCE_EN is defined, the synchronized step_req SHALL have to stay high for DEB_CYCLES consecutive cycles before it qualifies, and any low cycle SHALL restart the debounce count.
REQ-035 When CLK_CTRL_DEBOUNCE_EN is defined, step latency SHALL become DEB_CYCLES+4 cycles.
REQ-036 When CLK_CTRL_DEBOUNCE_EN is not defined, the debounce logic SHALL be absent and the latency in REQ-024 SHALL apply.

Structure
REQ-037 The package clk_ctrl_pkg SHALL hold the state encodings and the mode encodings (MODE_HALT, MODE_RUN, MODE_STEP).
REQ-038 The sub-module step_sync SHALL contain the 2-flop synchronizer, the optional debounce and the rising-edge detector, and output a single-cycle step_pulse.

Verification
REQ-039 Reset, RUN with DEFAULT_DIV=10 -> cpu_ce every 11 cycles; tick_count=5 after 55 cycles.
REQ-040 RUN, div_load with div_val=3 mid-period -> the current 11-cycle period completes, div_ack pulses at the wrap, then the period is 4 cycles.
REQ-041 STEP, step_req held high 20 cycles -> exactly one cpu_ce, 4 cycles after the rising edge; step_req toggled while in S_HALT -> no cpu_ce.
REQ-042 RUN, mode switched to HALT at div_cnt=7 -> no cpu_ce; back to RUN -> first cpu_ce 11 cycles later.
REQ-043 With CNT_W forced to 4: 16 pulses -> tick_count wraps to 0; clr_count coincident with cpu_ce -> tick_count=0.
REQ-044 With the debounce macro on and DEB_CYCLES=8: a 5-cycle glitch -> no cpu_ce; a 10-cycle press -> one cpu_ce at cycle 12.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_ctrl_pkg
//   Shared encodings for the CPU clock-enable controller: FSM state codes
//   (also driven out on clk_ctrl.state) and the operating-mode codes
//   presented on clk_ctrl.mode.
// -----------------------------------------------------------------------------
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        S_HALT      = 2'b00,
        S_RUN       = 2'b01,
        S_STEP_ARM  = 2'b10,
        S_STEP_FIRE = 2'b11
    } state_e;

    // Code 11 is reserved and behaves exactly like MODE_HALT.
    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

endpackage : clk_ctrl_pkg

// File: rtl/clk_ctrl_step_sync.sv
// -----------------------------------------------------------------------------
// step_sync
//   Conditions the asynchronous single-step button for the clk domain:
//   2-flop synchronizer, optional debounce, then a rising-edge detector that
//   emits a registered one-cycle step_pulse per qualified press.
//
//   Build option: CLK_CTRL_DEBOUNCE_EN -- when defined, the synchronized level
//   must stay high for DEB_CYCLES consecutive cycles before it qualifies; any
//   low cycle restarts the count. When undefined no debounce logic exists.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high
//   step_req   : raw step button, asynchronous, active-high
//   step_pulse : one-cycle pulse on each qualified 0->1 transition
// -----------------------------------------------------------------------------
module step_sync #(
    parameter int unsigned DEB_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic step_req,
    output logic step_pulse
);

    // A zero stable time would make the debounce counter meaningless.
    if (DEB_CYCLES < 1) begin : g_deb_cycles_check
        $error("step_sync: DEB_CYCLES must be at least 1");
    end

    logic sync1;
    logic sync2;
    logic step_lvl;   // qualified button level feeding the edge detector
    logic lvl_d;      // previous qualified level

    // NOTE: every register in this slice uses non-blocking assignment so all
    // flops sample the pre-edge values; blocking here would collapse the
    // synchronizer stages into a single flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= step_req;
            sync2 <= sync1;
        end
    end

`ifdef CLK_CTRL_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DEB_W-1:0] deb_cnt;
    logic             deb_lvl;

    // deb_cnt counts high cycles already seen; the level qualifies on the
    // DEB_CYCLES-th consecutive high sample and stays qualified while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt <= '0;
            deb_lvl <= 1'b0;
        end else if (!sync2) begin
            deb_cnt <= '0;
            deb_lvl <= 1'b0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            deb_lvl <= 1'b1;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign step_lvl = deb_lvl;
`else
    assign step_lvl = sync2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_d      <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            lvl_d      <= step_lvl;
            step_pulse <= step_lvl & ~lvl_d;
        end
    end

endmodule : step_sync

// File: rtl/clk_ctrl.sv
// -----------------------------------------------------------------------------
// clk_ctrl
//   Clock-enable controller for a CPU core. HALT: no enables. RUN: one
//   cpu_ce every div_reg+1 cycles. STEP: one cpu_ce per qualified press of
//   the step button. The divide ratio can be reloaded at run time; a load is
//   held pending until the current RUN period wraps (or applies on the next
//   cycle outside RUN) and is acknowledged with div_ack.
//
//   Build option: CLK_CTRL_DEBOUNCE_EN (see step_sync) adds DEB_CYCLES of
//   button debounce; step latency becomes DEB_CYCLES+4 instead of 4.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high
//   mode       : 00 HALT, 01 RUN, 10 STEP, 11 HALT
//   div_val    : new divide ratio (DIV_W bits)
//   div_load   : one-cycle request to load div_val
//   step_req   : asynchronous step button, active-high
//   clr_count  : synchronous clear of tick_count (wins over an increment)
//   cpu_ce     : one-cycle CPU clock-enable pulse
//   div_ack    : one-cycle pulse in the cycle a loaded ratio takes effect
//   tick_count : number of cpu_ce pulses issued, wraps modulo 2^CNT_W
//   state      : current FSM state encoding
// -----------------------------------------------------------------------------
module clk_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 10,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEB_CYCLES  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    input  logic             step_req,
    input  logic             clr_count,
    output logic             cpu_ce,
    output logic             div_ack,
    output logic [CNT_W-1:0] tick_count,
    output logic [1:0]       state
);

    state_e           state_q;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] pend_val;
    logic             pend;
    logic             step_pulse;
    logic             wrap;
    logic             fire;
    logic             apply;

    step_sync #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_sync (
        .clk        (clk),
        .reset      (reset),
        .step_req   (step_req),
        .step_pulse (step_pulse)
    );

    // Last cycle of a RUN period.
    assign wrap  = (state_q == S_RUN) && (div_cnt == div_reg);

    // An enable is issued only if the FSM stays in the issuing state: a wrap
    // while mode leaves RUN, or a step pulse while mode leaves STEP, is lost.
    assign fire  = ((mode == MODE_RUN) && wrap) ||
                   ((mode == MODE_STEP) && (state_q == S_STEP_ARM) && step_pulse);

    // A pending ratio waits for a period boundary inside RUN; elsewhere there
    // is no period in flight, so it lands on the next cycle.
    assign apply = pend && ((state_q != S_RUN) || wrap);

    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HALT;
            div_cnt <= '0;
            cpu_ce  <= 1'b0;
        end else begin
            cpu_ce <= fire;
            case (mode_e'(mode))
                MODE_RUN: begin
                    state_q <= S_RUN;
                    // Entering RUN from any other state restarts at 0.
                    if ((state_q == S_RUN) && !wrap) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                    end
                end
                MODE_STEP: begin
                    div_cnt <= '0;
                    case (state_q)
                        S_STEP_ARM:  state_q <= step_pulse ? S_STEP_FIRE : S_STEP_ARM;
                        S_STEP_FIRE: state_q <= S_STEP_ARM;
                        default:     state_q <= S_STEP_ARM;
                    endcase
                end
                default: begin
                    state_q <= S_HALT;
                    div_cnt <= '0;
                end
            endcase
        end
    end

    // A load in the same cycle as an apply refills the pending slot, so the
    // newer value is kept for the following boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg  <= DIV_W'(DEFAULT_DIV);
            pend_val <= '0;
            pend     <= 1'b0;
            div_ack  <= 1'b0;
        end else begin
            div_ack <= apply;
            if (apply) begin
                div_reg <= pend_val;
            end
            if (div_load) begin
                pend_val <= div_val;
                pend     <= 1'b1;
            end else if (apply) begin
                pend     <= 1'b0;
            end
        end
    end

    // Counts alongside cpu_ce so the count is current in the enable cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_count <= '0;
        end else if (clr_count) begin
            tick_count <= '0;
        end else if (fire) begin
            tick_count <= tick_count + CNT_W'(1);
        end
    end

endmodule : clk_ctrl

// File: tb/tb_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_ctrl
//   Directed bench for clk_ctrl. u_dut uses the default ratio of 10 and a
//   16-bit counter; u_small uses a ratio of 0 and a 4-bit counter to reach the
//   counter wrap quickly. Inputs change 1 ns after a rising edge and outputs
//   are sampled at the same point, so "edge k" below means the k-th rising
//   edge after the reference edge. With CLK_CTRL_DEBOUNCE_EN defined the
//   step latencies grow by DEB_CYCLES (8 here).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_ctrl;

    localparam int DEB = 8;
`ifdef CLK_CTRL_DEBOUNCE_EN
    localparam int STEP_LAT = DEB + 4;
`else
    localparam int STEP_LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [7:0]  div_val;
    logic        div_load;
    logic        step_req;
    logic        clr_count;
    logic        cpu_ce;
    logic        div_ack;
    logic [15:0] tick_count;
    logic [1:0]  state;

    logic [1:0]  s_mode;
    logic [7:0]  s_div_val;
    logic        s_div_load;
    logic        s_step_req;
    logic        s_clr;
    logic        s_cpu_ce;
    logic        s_div_ack;
    logic [3:0]  s_tick;
    logic [1:0]  s_state;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    clk_ctrl #(.DIV_W(8), .DEFAULT_DIV(10), .CNT_W(16), .DEB_CYCLES(DEB)) u_dut (
        .clk(clk), .reset(reset), .mode(mode), .div_val(div_val),
        .div_load(div_load), .step_req(step_req), .clr_count(clr_count),
        .cpu_ce(cpu_ce), .div_ack(div_ack), .tick_count(tick_count), .state(state)
    );

    clk_ctrl #(.DIV_W(8), .DEFAULT_DIV(0), .CNT_W(4), .DEB_CYCLES(DEB)) u_small (
        .clk(clk), .reset(reset), .mode(s_mode), .div_val(s_div_val),
        .div_load(s_div_load), .step_req(s_step_req), .clr_count(s_clr),
        .cpu_ce(s_cpu_ce), .div_ack(s_div_ack), .tick_count(s_tick), .state(s_state)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mode = 2'b00; div_val = '0; div_load = 1'b0; step_req = 1'b0; clr_count = 1'b0;
        s_mode = 2'b00; s_div_val = '0; s_div_load = 1'b0; s_step_req = 1'b0; s_clr = 1'b0;
        repeat (3) cyc();
        vectors++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
        vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_cpu_ce: got %b want 0", cpu_ce); end
        vectors++; if (div_ack !== 1'b0) begin errors++; $display("FAIL reset_div_ack: got %b want 0", div_ack); end
        vectors++; if (tick_count !== 16'd0) begin errors++; $display("FAIL reset_tick: got %0d want 0", tick_count); end
        vectors++; if (s_tick !== 4'd0) begin errors++; $display("FAIL reset_small_tick: got %0d want 0", s_tick); end
        reset = 1'b0;
        cyc();
        vectors++; if (state !== 2'b00) begin errors++; $display("FAIL post_reset_state: got %b want 00", state); end
    endtask

    // Ratio 0: enable on every RUN cycle; 4-bit count wraps; clear beats count.
    task automatic test_tick_wrap();
        s_mode = 2'b01;
        cyc();
        vectors++; if (s_cpu_ce !== 1'b0) begin errors++; $display("FAIL small_entry_ce: got %b want 0", s_cpu_ce); end
        for (int k = 1; k <= 16; k++) begin
            cyc();
            vectors++; if (s_cpu_ce !== 1'b1) begin errors++; $display("FAIL small_ce k=%0d: got %b want 1", k, s_cpu_ce); end
            vectors++; if (s_tick !== 4'(k % 16)) begin errors++; $display("FAIL small_tick k=%0d: got %0d want %0d", k, s_tick, k % 16); end
        end
        s_clr = 1'b1;
        cyc();
        s_clr = 1'b0;
        vectors++; if (s_cpu_ce !== 1'b1) begin errors++; $display("FAIL clr_ce: got %b want 1", s_cpu_ce); end
        vectors++; if (s_tick !== 4'd0) begin errors++; $display("FAIL clr_wins: got %0d want 0", s_tick); end
        cyc();
        vectors++; if (s_tick !== 4'd1) begin errors++; $display("FAIL after_clr: got %0d want 1", s_tick); end
        s_mode = 2'b00;
        cyc();
        vectors++; if (s_cpu_ce !== 1'b0) begin errors++; $display("FAIL small_halt_ce: got %b want 0", s_cpu_ce); end
    endtask

    task automatic test_run_default();
        mode = 2'b01;
        cyc();
        vectors++; if (state !== 2'b01) begin errors++; $display("FAIL run_state: got %b want 01", state); end
        for (int k = 1; k <= 55; k++) begin
            cyc();
            vectors++;
            if (cpu_ce !== ((k % 11) == 0)) begin
                errors++; $display("FAIL run_ce k=%0d: got %b want %b", k, cpu_ce, (k % 11) == 0);
            end
        end
        vectors++; if (tick_count !== 16'd5) begin errors++; $display("FAIL run_tick55: got %0d want 5", tick_count); end
    endtask

    task automatic test_div_load();
        logic exp_ce;
        logic exp_ack;
        // Load 3 mid-period: the 11-cycle period ends at edge 11, then period 4.
        div_val = 8'd3;
        for (int k = 1; k <= 23; k++) begin
            div_load = (k == 3);
            cyc();
            exp_ce  = (k == 11) || (k == 15) || (k == 19) || (k == 23);
            exp_ack = (k == 11);
            vectors++; if (cpu_ce !== exp_ce) begin errors++; $display("FAIL load3_ce k=%0d: got %b want %b", k, cpu_ce, exp_ce); end
            vectors++; if (div_ack !== exp_ack) begin errors++; $display("FAIL load3_ack k=%0d: got %b want %b", k, div_ack, exp_ack); end
        end
        // Two loads while pending: only the second (2) applies, one ack.
        for (int k = 1; k <= 10; k++) begin
            div_load = (k == 1) || (k == 2);
            div_val  = (k == 1) ? 8'd5 : 8'd2;
            cyc();
            exp_ce  = (k == 4) || (k == 7) || (k == 10);
            exp_ack = (k == 4);
            vectors++; if (cpu_ce !== exp_ce) begin errors++; $display("FAIL overwrite_ce k=%0d: got %b want %b", k, cpu_ce, exp_ce); end
            vectors++; if (div_ack !== exp_ack) begin errors++; $display("FAIL overwrite_ack k=%0d: got %b want %b", k, div_ack, exp_ack); end
        end
        // Load 1 on a wrap edge: one more period of 3, then period 2.
        div_val = 8'd1;
        for (int k = 1; k <= 10; k++) begin
            div_load = (k == 3);
            cyc();
            exp_ce  = (k == 3) || (k == 6) || (k == 8) || (k == 10);
            exp_ack = (k == 6);
            vectors++; if (cpu_ce !== exp_ce) begin errors++; $display("FAIL wrapload_ce k=%0d: got %b want %b", k, cpu_ce, exp_ce); end
            vectors++; if (div_ack !== exp_ack) begin errors++; $display("FAIL wrapload_ack k=%0d: got %b want %b", k, div_ack, exp_ack); end
        end
        div_load = 1'b0;
    endtask

    task automatic test_halt_resume();
        mode = 2'b00;
        cyc();
        vectors++; if (state !== 2'b00) begin errors++; $display("FAIL halt_state: got %b want 00", state); end
        // Outside RUN a load applies on the following cycle.
        div_val = 8'd10; div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        vectors++; if (div_ack !== 1'b0) begin errors++; $display("FAIL halt_load_ack0: got %b want 0", div_ack); end
        cyc();
        vectors++; if (div_ack !== 1'b1) begin errors++; $display("FAIL halt_load_ack1: got %b want 1", div_ack); end
        cyc();
        vectors++; if (div_ack !== 1'b0) begin errors++; $display("FAIL halt_load_ack2: got %b want 0", div_ack); end
        mode = 2'b01;
        cyc();
        for (int k = 1; k <= 7; k++) begin
            cyc();
            vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL pre_halt_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        mode = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL halted_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        mode = 2'b01;
        cyc();
        for (int k = 1; k <= 22; k++) begin
            cyc();
            vectors++;
            if (cpu_ce !== ((k == 11) || (k == 22))) begin
                errors++; $display("FAIL resume_ce k=%0d: got %b want %b", k, cpu_ce, (k == 11) || (k == 22));
            end
        end
    endtask

    task automatic test_step();
        mode = 2'b10;
        cyc();
        vectors++; if (state !== 2'b10) begin errors++; $display("FAIL arm_state: got %b want 10", state); end
        repeat (2) cyc();
        step_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            vectors++;
            if (cpu_ce !== (k == STEP_LAT)) begin
                errors++; $display("FAIL step_ce k=%0d: got %b want %b", k, cpu_ce, k == STEP_LAT);
            end
            if (k == STEP_LAT) begin
                vectors++; if (state !== 2'b11) begin errors++; $display("FAIL fire_state: got %b want 11", state); end
            end
            if (k == STEP_LAT + 1) begin
                vectors++; if (state !== 2'b10) begin errors++; $display("FAIL rearm_state: got %b want 10", state); end
            end
        end
        step_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL step_release_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
    endtask

    task automatic test_step_discard();
        mode = 2'b00;
        cyc();
        for (int k = 1; k <= 12; k++) begin
            step_req = (((k - 1) / 3) % 2) == 0;
            cyc();
            vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL halt_toggle_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        // Press lands in HALT; entering STEP while still held must not fire.
        step_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL halt_press_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        mode = 2'b10;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL no_queue_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        vectors++; if (state !== 2'b10) begin errors++; $display("FAIL no_queue_state: got %b want 10", state); end
        step_req = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_short_press();
`ifdef CLK_CTRL_DEBOUNCE_EN
        for (int k = 1; k <= 20; k++) begin
            step_req = (k <= 5);
            cyc();
            vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL glitch_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        for (int k = 1; k <= 20; k++) begin
            step_req = (k <= 10);
            cyc();
            vectors++; if (cpu_ce !== (k == 12)) begin errors++; $display("FAIL press10_ce k=%0d: got %b want %b", k, cpu_ce, k == 12); end
        end
`else
        for (int k = 1; k <= 10; k++) begin
            step_req = (k == 1);
            cyc();
            vectors++; if (cpu_ce !== (k == 4)) begin errors++; $display("FAIL press1_ce k=%0d: got %b want %b", k, cpu_ce, k == 4); end
        end
`endif
        step_req = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_reset_mid();
        mode = 2'b01;
        cyc();
        repeat (5) cyc();
        reset = 1'b1;
        #1;
        vectors++; if (state !== 2'b00) begin errors++; $display("FAIL midrun_reset_state: got %b want 00", state); end
        vectors++; if (tick_count !== 16'd0) begin errors++; $display("FAIL midrun_reset_tick: got %0d want 0", tick_count); end
        repeat (2) cyc();
        vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL midrun_reset_ce: got %b want 0", cpu_ce); end
        reset = 1'b0;
        cyc();
        vectors++; if (state !== 2'b01) begin errors++; $display("FAIL post_reset_run: got %b want 01", state); end
        for (int k = 1; k <= 11; k++) begin
            cyc();
            vectors++; if (cpu_ce !== (k == 11)) begin errors++; $display("FAIL post_reset_ce k=%0d: got %b want %b", k, cpu_ce, k == 11); end
        end
        vectors++; if (tick_count !== 16'd1) begin errors++; $display("FAIL post_reset_tick: got %0d want 1", tick_count); end
        // Abort a step while it is still in the synchronizer.
        mode = 2'b10;
        cyc();
        step_req = 1'b1;
        repeat (2) cyc();
        reset = 1'b1;
        step_req = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL midstep_reset_ce k=%0d: got %b want 0", k, cpu_ce); end
        end
        vectors++; if (state !== 2'b10) begin errors++; $display("FAIL midstep_reset_state: got %b want 10", state); end
    endtask

    initial begin
        test_reset();
        test_tick_wrap();
        test_run_default();
        test_div_load();
        test_halt_resume();
        test_step();
        test_step_discard();
        test_short_press();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_clk_ctrl
